// File: rtl/regfile32x32.sv
// MIPS register file: 32 x 32-bit, two combinational read ports, one synchronous write port.
// Define REGFILE_WRITE_BYPASS_EN to forward same-cycle write data to the read ports.
`timescale 1ns/1ps
module regfile32x32 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned REG_COUNT  = 32
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [ADDR_WIDTH-1:0] RdAddr1,
  input  logic [ADDR_WIDTH-1:0] RdAddr2,
  output logic [DATA_WIDTH-1:0] RdData1,
  output logic [DATA_WIDTH-1:0] RdData2,
  input  logic                  WrEn,
  input  logic [ADDR_WIDTH-1:0] WrAddr,
  input  logic [DATA_WIDTH-1:0] WrData
);

  logic [DATA_WIDTH-1:0] regs [REG_COUNT];

  // The async clear wins over a coincident clock edge, so writes under reset are dropped.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (WrEn && (WrAddr != '0)) begin
      regs[WrAddr] <= WrData;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] data;
    data = regs[addr];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (WrEn && (addr == WrAddr)) begin
      data = WrData;
    end
`endif
    // r0 and reset override everything, including the forwarding path.
    if ((addr == '0) || !Rst_n) begin
      data = '0;
    end
    return data;
  endfunction

  always_comb begin
    RdData1 = read_port(RdAddr1);
    RdData2 = read_port(RdAddr2);
  end

endmodule

// File: tb/tb_regfile32x32.sv
// Self-checking bench for regfile32x32: directed scenarios plus randomized traffic
// checked against an array-based reference model.
`timescale 1ns/1ps
module tb_regfile32x32;

  logic        Clk;
  logic        Rst_n;
  logic [4:0]  RdAddr1, RdAddr2, WrAddr;
  logic [31:0] RdData1, RdData2, WrData;
  logic        WrEn;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] model [32];

  regfile32x32 #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .REG_COUNT(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .RdAddr1(RdAddr1), .RdAddr2(RdAddr2),
    .RdData1(RdData1), .RdData2(RdData2),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (!Rst_n || a == 5'd0) return 32'h0;
`ifdef REGFILE_WRITE_BYPASS_EN
    if (WrEn && a == WrAddr) return WrData;
`endif
    return model[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge Clk);
    WrEn = 1'b1; WrAddr = a; WrData = d;
    @(posedge Clk); #1;
    if (a != 5'd0) model[a] = d;
    WrEn = 1'b0;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    WrEn = 1'b1; WrAddr = 5'd9; WrData = 32'h5A5A5A5A;
    clear_model();
    for (int i = 0; i < 32; i++) begin
      RdAddr1 = 5'(i); RdAddr2 = 5'(31 - i);
      #1;
      checks++;
      if (RdData1 !== 32'h0) begin
        errors++; $display("FAIL reset_rd1 addr=%0d got=%h exp=%h", i, RdData1, 32'h0);
      end
      checks++;
      if (RdData2 !== 32'h0) begin
        errors++; $display("FAIL reset_rd2 addr=%0d got=%h exp=%h", 31 - i, RdData2, 32'h0);
      end
    end
    // Edges under reset with WrEn=1 must not write.
    @(posedge Clk); @(posedge Clk); #1;
    WrEn = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    RdAddr1 = 5'd9; #1;
    checks++;
    if (RdData1 !== 32'h0) begin
      errors++; $display("FAIL write_under_reset got=%h exp=%h", RdData1, 32'h0);
    end
  endtask

  task automatic test_release_write();
    @(negedge Clk);
    Rst_n = 1'b0;
    clear_model();
    #1 Rst_n = 1'b1;
    WrEn = 1'b1; WrAddr = 5'd5; WrData = 32'hDEADBEEF;
    RdAddr1 = 5'd5;
    @(posedge Clk); #1;
    model[5] = 32'hDEADBEEF;
    WrEn = 1'b0;
    checks++;
    if (RdData1 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL release_write got=%h exp=%h", RdData1, 32'hDEADBEEF);
    end
  endtask

  task automatic test_write_all();
    for (int i = 1; i < 32; i++) do_write(5'(i), 32'h1000_0000 + 32'(i));
    for (int i = 0; i < 32; i++) begin
      logic [31:0] e1, e2;
      RdAddr1 = 5'(i); RdAddr2 = 5'(31 - i);
      e1 = (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i);
      e2 = (i == 31) ? 32'h0 : 32'h1000_0000 + 32'(31 - i);
      #1;
      checks++;
      if (RdData1 !== e1) begin
        errors++; $display("FAIL write_all_rd1 addr=%0d got=%h exp=%h", i, RdData1, e1);
      end
      checks++;
      if (RdData2 !== e2) begin
        errors++; $display("FAIL write_all_rd2 addr=%0d got=%h exp=%h", 31 - i, RdData2, e2);
      end
    end
    RdAddr1 = 5'd17; RdAddr2 = 5'd17; #1;
    checks++;
    if (RdData1 !== 32'h1000_0011 || RdData2 !== RdData1) begin
      errors++; $display("FAIL same_addr got=%h/%h exp=%h", RdData1, RdData2, 32'h1000_0011);
    end
  endtask

  task automatic test_r0();
    @(negedge Clk);
    WrEn = 1'b1; WrAddr = 5'd0; WrData = 32'hFFFFFFFF;
    RdAddr1 = 5'd0; RdAddr2 = 5'd0;
    #1;
    checks++;
    if (RdData2 !== 32'h0) begin
      errors++; $display("FAIL r0_pre_edge got=%h exp=%h", RdData2, 32'h0);
    end
    @(posedge Clk); #1;
    WrEn = 1'b0;
    @(negedge Clk); #1;
    checks++;
    if (RdData1 !== 32'h0) begin
      errors++; $display("FAIL r0_after_write got=%h exp=%h", RdData1, 32'h0);
    end
  endtask

  task automatic test_read_during_write();
    logic [31:0] pre_exp;
    do_write(5'd7, 32'h11111111);
    @(negedge Clk);
    WrEn = 1'b1; WrAddr = 5'd7; WrData = 32'h22222222; RdAddr2 = 5'd7;
    #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    pre_exp = 32'h22222222;
`else
    pre_exp = 32'h11111111;
`endif
    checks++;
    if (RdData2 !== pre_exp) begin
      errors++; $display("FAIL rdw_pre_edge got=%h exp=%h", RdData2, pre_exp);
    end
    @(posedge Clk); #1;
    model[7] = 32'h22222222;
    WrEn = 1'b0;
    checks++;
    if (RdData2 !== 32'h22222222) begin
      errors++; $display("FAIL rdw_post_edge got=%h exp=%h", RdData2, 32'h22222222);
    end
  endtask

  task automatic test_wren_gating();
    do_write(5'd3, 32'h33333333);
    @(negedge Clk);
    WrEn = 1'b0; WrAddr = 5'd3; WrData = 32'hABCD0123; RdAddr1 = 5'd3;
    for (int k = 0; k < 4; k++) begin
      @(posedge Clk); #1;
      checks++;
      if (RdData1 !== 32'h33333333) begin
        errors++; $display("FAIL wren_gating edge=%0d got=%h exp=%h", k, RdData1, 32'h33333333);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_write(5'd10, 32'h0000CAFE);
    @(negedge Clk);
    RdAddr1 = 5'd10; #1;
    checks++;
    if (RdData1 !== 32'h0000CAFE) begin
      errors++; $display("FAIL mid_reset_setup got=%h exp=%h", RdData1, 32'h0000CAFE);
    end
    Rst_n = 1'b0;
    #0.5;
    checks++;
    if (RdData1 !== 32'h0) begin
      errors++; $display("FAIL mid_reset_drop got=%h exp=%h", RdData1, 32'h0);
    end
    #0.5 Rst_n = 1'b1;
    clear_model();
    #0.5;
    checks++;
    if (RdData1 !== 32'h0) begin
      errors++; $display("FAIL mid_reset_cleared got=%h exp=%h", RdData1, 32'h0);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      @(negedge Clk);
      WrEn    = ($urandom_range(3) != 0);
      WrAddr  = 5'($urandom_range(31));
      WrData  = $urandom;
      RdAddr1 = ($urandom_range(3) == 0) ? WrAddr : 5'($urandom_range(31));
      RdAddr2 = ($urandom_range(3) == 0) ? WrAddr : 5'($urandom_range(31));
      #2;
      checks++;
      if (RdData1 !== exp_read(RdAddr1)) begin
        errors++; $display("FAIL rand_pre_rd1 addr=%0d got=%h exp=%h", RdAddr1, RdData1, exp_read(RdAddr1));
      end
      checks++;
      if (RdData2 !== exp_read(RdAddr2)) begin
        errors++; $display("FAIL rand_pre_rd2 addr=%0d got=%h exp=%h", RdAddr2, RdData2, exp_read(RdAddr2));
      end
      @(posedge Clk); #1;
      if (WrEn && WrAddr != 5'd0) model[WrAddr] = WrData;
      checks++;
      if (RdData1 !== exp_read(RdAddr1)) begin
        errors++; $display("FAIL rand_post_rd1 addr=%0d got=%h exp=%h", RdAddr1, RdData1, exp_read(RdAddr1));
      end
      checks++;
      if (RdData2 !== exp_read(RdAddr2)) begin
        errors++; $display("FAIL rand_post_rd2 addr=%0d got=%h exp=%h", RdAddr2, RdData2, exp_read(RdAddr2));
      end
    end
    WrEn = 1'b0;
  endtask

  initial begin
    Rst_n = 1'b0; WrEn = 1'b0; WrAddr = '0; WrData = '0;
    RdAddr1 = '0; RdAddr2 = '0;
    test_reset();
    test_release_write();
    test_write_all();
    test_r0();
    test_read_during_write();
    test_wren_gating();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
